// File: rtl/mac_col_sched_if.sv
// rtl/mac_col_sched_if.sv - control, SRAM-strobe and result bundle of one MAC column sequencer
interface mac_col_sched_if #(
    parameter int ROWS = 8,
    parameter int AW   = 10,
    parameter int LW   = 10
);
    logic            start;
    logic            abort;
    logic            cfg_skip_wld;
    logic [LW-1:0]   cfg_len;
    logic [AW-1:0]   cfg_w_base;
    logic [AW-1:0]   cfg_a_base;
    logic            busy;
    logic            done;
    logic            w_rd_en;
    logic [AW-1:0]   w_addr;
    logic [ROWS-1:0] w_en;
    logic            a_rd_en;
    logic [AW-1:0]   a_addr;
    logic            out_valid;
    logic [LW-1:0]   out_idx;

    modport master (
        output start, abort, cfg_skip_wld, cfg_len, cfg_w_base, cfg_a_base,
        input  busy, done, w_rd_en, w_addr, w_en, a_rd_en, a_addr, out_valid, out_idx
    );

    modport slave (
        input  start, abort, cfg_skip_wld, cfg_len, cfg_w_base, cfg_a_base,
        output busy, done, w_rd_en, w_addr, w_en, a_rd_en, a_addr, out_valid, out_idx
    );
endinterface

// File: rtl/mac_col_sched.sv
// rtl/mac_col_sched.sv - weight-load / activation-stream sequencer for one weight-stationary MAC column
module mac_col_sched #(
    parameter int ROWS   = 8,
    parameter int AW     = 10,
    parameter int LW     = 10,
    parameter int RD_LAT = 1,
    parameter int X_LAT  = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    mac_col_sched_if.slave   bus
);
    localparam int SKEW = X_LAT - 1;
    localparam int LAT  = RD_LAT + X_LAT + SKEW * (ROWS - 1);

    typedef enum logic [2:0] {IDLE, WLOAD, WWAIT, STREAM, DRAIN, FIN} state_t;

    state_t          state;
    logic [LW-1:0]   cnt;
    logic            skip_r;
    logic [LW-1:0]   len_r;
    logic [AW-1:0]   w_base_r;
    logic [AW-1:0]   a_base_r;

    logic            busy_r;
    logic            done_r;
    logic            w_rd_en_r;
    logic [AW-1:0]   w_addr_r;
    logic [ROWS-1:0] w_sel;
    logic            a_rd_en_r;
    logic [AW-1:0]   a_addr_r;
    logic [LW-1:0]   out_idx_r;

    logic [ROWS-1:0] wline [RD_LAT];
    logic [LAT-1:0]  vline;

    // Outputs are registered: each branch sets what the next cycle shows.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            skip_r    <= 1'b0;
            len_r     <= '0;
            w_base_r  <= '0;
            a_base_r  <= '0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            w_rd_en_r <= 1'b0;
            w_addr_r  <= '0;
            w_sel     <= '0;
            a_rd_en_r <= 1'b0;
            a_addr_r  <= '0;
            out_idx_r <= '0;
        end else begin
            done_r    <= 1'b0;
            w_rd_en_r <= 1'b0;
            a_rd_en_r <= 1'b0;
            if (vline[LAT-1]) out_idx_r <= out_idx_r + 1'b1;
            if (bus.abort) begin
                state     <= IDLE;
                cnt       <= '0;
                busy_r    <= 1'b0;
                w_sel     <= '0;
                out_idx_r <= '0;
            end else begin
                case (state)
                    IDLE: if (bus.start) begin
                        skip_r    <= bus.cfg_skip_wld;
                        len_r     <= bus.cfg_len;
                        w_base_r  <= bus.cfg_w_base;
                        a_base_r  <= bus.cfg_a_base;
                        busy_r    <= 1'b1;
                        out_idx_r <= '0;
                        cnt       <= LW'(1);
                        if (!bus.cfg_skip_wld) begin
                            state     <= WLOAD;
                            w_rd_en_r <= 1'b1;
                            w_addr_r  <= bus.cfg_w_base;
                            w_sel     <= ROWS'(1);
                        end else if (bus.cfg_len != '0) begin
                            state     <= STREAM;
                            a_rd_en_r <= 1'b1;
                            a_addr_r  <= bus.cfg_a_base;
                        end else begin
                            state  <= FIN;
                            done_r <= 1'b1;
                        end
                    end
                    WLOAD: begin
                        if (cnt < LW'(ROWS)) begin
                            w_rd_en_r <= 1'b1;
                            w_addr_r  <= w_base_r + AW'(cnt);
                            w_sel     <= w_sel << 1;
                            cnt       <= cnt + 1'b1;
                        end else begin
                            state <= WWAIT;
                            cnt   <= LW'(1);
                        end
                    end
                    WWAIT: begin
                        if (cnt >= LW'(RD_LAT)) begin
                            cnt <= LW'(1);
                            if (len_r != '0) begin
                                state     <= STREAM;
                                a_rd_en_r <= 1'b1;
                                a_addr_r  <= a_base_r;
                            end else begin
                                state  <= FIN;
                                done_r <= 1'b1;
                            end
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    STREAM: begin
                        if (cnt < len_r) begin
                            a_rd_en_r <= 1'b1;
                            a_addr_r  <= a_base_r + AW'(cnt);
                            cnt       <= cnt + 1'b1;
                        end else begin
                            state <= DRAIN;
                        end
                    end
                    DRAIN: begin
                        // Leave on the last beat so FIN lands one cycle after it.
                        if (vline[LAT-1] && out_idx_r == len_r - LW'(1)) begin
                            state  <= FIN;
                            done_r <= 1'b1;
                        end
                    end
                    FIN: begin
                        state  <= IDLE;
                        busy_r <= 1'b0;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    // Delay lines: read strobe -> row capture, and activation read -> column result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < RD_LAT; i++) wline[i] <= '0;
            vline <= '0;
        end else if (bus.abort) begin
            for (int i = 0; i < RD_LAT; i++) wline[i] <= '0;
            vline <= '0;
        end else begin
            wline[0] <= w_rd_en_r ? w_sel : '0;
            for (int i = 1; i < RD_LAT; i++) wline[i] <= wline[i-1];
            vline <= {vline[LAT-2:0], a_rd_en_r};
        end
    end

    assign bus.busy      = busy_r;
    assign bus.done      = done_r;
    assign bus.w_rd_en   = w_rd_en_r;
    assign bus.w_addr    = w_addr_r;
    assign bus.w_en      = wline[RD_LAT-1];
    assign bus.a_rd_en   = a_rd_en_r;
    assign bus.a_addr    = a_addr_r;
    assign bus.out_valid = vline[LAT-1];
    assign bus.out_idx   = out_idx_r;
endmodule

// File: tb/tb_mac_col_sched.sv
// tb/tb_mac_col_sched.sv - randomized cycle-trace check of mac_col_sched against a timing-formula model
module tb_mac_col_sched;
    localparam int ROWS   = 8;
    localparam int AW     = 10;
    localparam int LW     = 10;
    localparam int RD_LAT = 1;
    localparam int X_LAT  = 3;
    localparam int LAT    = RD_LAT + X_LAT + (X_LAT - 1) * (ROWS - 1);

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;

    always #5 clk = ~clk;

    mac_col_sched_if #(.ROWS(ROWS), .AW(AW), .LW(LW)) bus ();

    mac_col_sched #(.ROWS(ROWS), .AW(AW), .LW(LW), .RD_LAT(RD_LAT), .X_LAT(X_LAT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s cycle %0d: got 0x%0h expected 0x%0h", tag, cyc, got, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, 32'(bus.busy), 0);
        check({tag, "_done"}, 32'(bus.done), 0);
        check({tag, "_wrd"}, 32'(bus.w_rd_en), 0);
        check({tag, "_waddr"}, 32'(bus.w_addr), 0);
        check({tag, "_wen"}, 32'(bus.w_en), 0);
        check({tag, "_ard"}, 32'(bus.a_rd_en), 0);
        check({tag, "_aaddr"}, 32'(bus.a_addr), 0);
        check({tag, "_ov"}, 32'(bus.out_valid), 0);
        check({tag, "_idx"}, 32'(bus.out_idx), 0);
    endtask

    // Expected trace from the job's timing rules: weight phase ROWS+RD_LAT cycles,
    // reads back to back, each result LAT cycles after its read, done one cycle after the last.
    task automatic run_job(input logic skip, input int len, input logic [AW-1:0] wb,
                           input logic [AW-1:0] ab, input int abort_at, input int restart_at);
        int tw, done_c, last;
        logic alive, e_wrd, e_ard, e_ov;
        logic [ROWS-1:0] e_wen;
        tw     = skip ? 0 : ROWS + RD_LAT;
        done_c = (len == 0) ? tw + 1 : tw + len + LAT + 1;
        last   = (abort_at > 0) ? abort_at + LAT + 2 : done_c + 3;
        @(negedge clk);
        bus.start = 1'b1;
        bus.cfg_skip_wld = skip;
        bus.cfg_len = LW'(len);
        bus.cfg_w_base = wb;
        bus.cfg_a_base = ab;
        for (int c = 1; c <= last; c++) begin
            @(negedge clk);
            cyc = c;
            bus.start = 1'b0;
            alive = (abort_at == 0) || (c <= abort_at);
            e_wrd = alive && !skip && c >= 1 && c <= ROWS;
            e_wen = (alive && !skip && c >= 1 + RD_LAT && c <= ROWS + RD_LAT)
                    ? ROWS'(1) << (c - 1 - RD_LAT) : '0;
            e_ard = alive && c >= tw + 1 && c <= tw + len;
            e_ov  = alive && c >= tw + 1 + LAT && c <= tw + len + LAT;
            check("w_rd_en", 32'(bus.w_rd_en), 32'(e_wrd));
            if (e_wrd) check("w_addr", 32'(bus.w_addr), 32'(AW'(wb + AW'(c - 1))));
            check("w_en", 32'(bus.w_en), 32'(e_wen));
            check("a_rd_en", 32'(bus.a_rd_en), 32'(e_ard));
            if (e_ard) check("a_addr", 32'(bus.a_addr), 32'(AW'(ab + AW'(c - tw - 1))));
            check("out_valid", 32'(bus.out_valid), 32'(e_ov));
            if (e_ov) check("out_idx", 32'(bus.out_idx), 32'(c - tw - 1 - LAT));
            check("done", 32'(bus.done), 32'(alive && c == done_c));
            check("busy", 32'(bus.busy), 32'(alive && c <= done_c));
            bus.abort = (c == abort_at);
            if (c == restart_at) begin
                bus.start = 1'b1;
                bus.cfg_skip_wld = 1'($urandom);
                bus.cfg_len = LW'($urandom_range(0, 9));
                bus.cfg_w_base = AW'($urandom);
                bus.cfg_a_base = AW'($urandom);
            end
        end
        bus.abort = 1'b0;
        bus.start = 1'b0;
    endtask

    initial begin
        bus.start = 1'b0;
        bus.abort = 1'b0;
        bus.cfg_skip_wld = 1'b0;
        bus.cfg_len = '0;
        bus.cfg_w_base = '0;
        bus.cfg_a_base = '0;
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check_all_zero("idle");

        run_job(1'b0, 4, 10'h010, 10'h020, 0, 0);
        run_job(1'b1, 2, 10'h000, 10'h100, 0, 0);
        run_job(1'b0, 0, 10'h3F0, 10'h000, 0, 0);
        run_job(1'b1, 0, 10'h000, 10'h000, 0, 0);
        run_job(1'b0, 4, 10'h010, 10'h020, 0, 11);
        run_job(1'b0, 4, 10'h010, 10'h020, 12, 0);
        run_job(1'b1, 4, 10'h3FC, 10'h3FE, 0, 0);
        run_job(1'b0, 3, 10'h3FD, 10'h3FF, 0, 0);

        // Asynchronous reset in the middle of the activation stream.
        @(negedge clk);
        bus.start = 1'b1;
        bus.cfg_skip_wld = 1'b0;
        bus.cfg_len = LW'(4);
        bus.cfg_w_base = 10'h010;
        bus.cfg_a_base = 10'h020;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (10) @(negedge clk);
        cyc = 11;
        check("pre_rst_ard", 32'(bus.a_rd_en), 1);
        #2 rst_n = 1'b0;
        #1 check_all_zero("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("post_rst_busy", 32'(bus.busy), 0);
            check("post_rst_ard", 32'(bus.a_rd_en), 0);
            check("post_rst_ov", 32'(bus.out_valid), 0);
        end
        run_job(1'b0, 2, 10'h055, 10'h0AA, 0, 0);

        for (int j = 0; j < 10; j++) begin
            logic sk;
            int ln, ab_at, dc;
            sk = 1'($urandom);
            ln = $urandom_range(0, 12);
            dc = (ln == 0) ? (sk ? 0 : ROWS + RD_LAT) + 1 : (sk ? 0 : ROWS + RD_LAT) + ln + LAT + 1;
            ab_at = (j % 3 == 2 && dc > 1) ? $urandom_range(1, dc - 1) : 0;
            run_job(sk, ln, AW'($urandom), AW'($urandom), ab_at, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
